pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 120 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int CNT_W  = 16;
    localparam int LOSS_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        QUALIFY    = 2'd1,
        RESET_HOLD = 2'd2,
        RUN        = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by an async reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, holds a downstream reset for a fixed time, then releases it.
// Optional lock-loss counter is compiled in with `define PLL_LOSS_COUNT_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_QUAL_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              locked,
    output logic              rst_out,
    output logic              ready,
    output logic              lock_lost,
    output logic [1:0]        state,
    output logic [LOSS_W-1:0] loss_count
);

    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic             locked_s;
    seq_state_t       state_q;
    seq_state_t       next_state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lost_event;

    sync_2ff u_sync (
        .clk (clock_in),
        .rst (reset),
        .d   (locked),
        .q   (locked_s)
    );

    // Losing lock before acceptance just restarts qualification; after acceptance it is an event.
    always_comb begin
        next_state = state_q;
        cnt_d      = cnt_q;
        lost_event = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = QUALIFY;
                    cnt_d      = '0;
                end
            end
            QUALIFY: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    cnt_d      = '0;
                end else if (cnt_q == QUAL_LAST) begin
                    next_state = RESET_HOLD;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESET_HOLD: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    cnt_d      = '0;
                    lost_event = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    next_state = RUN;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    cnt_d      = '0;
                    lost_event = 1'b1;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                cnt_d      = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            rst_out   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= next_state;
            cnt_q     <= cnt_d;
            rst_out   <= (next_state != RUN);
            ready     <= (next_state == RUN);
            lock_lost <= lost_event;
        end
    end

    assign state = state_q;

`ifdef PLL_LOSS_COUNT_EN
    logic [LOSS_W-1:0] loss_q;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if (lost_event && (loss_q != {LOSS_W{1'b1}})) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed vector table plus randomized run against a lock-history model.
module tb_pll_reset_sequencer;

    localparam int Q = 8;
    localparam int H = 4;
`ifdef PLL_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       locked   = 1'b0;
    logic       rst_out;
    logic       ready;
    logic       lock_lost;
    logic [1:0] state;
    logic [7:0] loss_count;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    pll_reset_sequencer #(
        .LOCK_QUAL_CYCLES  (Q),
        .RESET_HOLD_CYCLES (H)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .locked     (locked),
        .rst_out    (rst_out),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .state      (state),
        .loss_count (loss_count)
    );

    always #5 clock_in = ~clock_in;

    // Model: the sequencer is fully described by how many consecutive edges have seen a high synchronized lock.
    logic pipe0, pipe1, ls;
    int   k, prev_k, m_loss;
    logic m_lost;

    always @(posedge clock_in or posedge reset) begin
        if (reset) begin
            pipe0 = 1'b0; pipe1 = 1'b0; ls = 1'b0;
            k = 0; m_lost = 1'b0; m_loss = 0;
        end else begin
            ls     = pipe0;
            pipe0  = pipe1;
            pipe1  = locked;
            prev_k = k;
            k      = ls ? ((k < 100000) ? k + 1 : k) : 0;
            m_lost = !ls && (prev_k >= Q + 1);
            if (m_lost && m_loss < 255) m_loss = m_loss + 1;
        end
    end

    function automatic int expState(int kk);
        if (kk == 0) return 0;
        if (kk <= Q) return 1;
        if (kk <= Q + H) return 2;
        return 3;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int es;
        es = expState(k);
        cmp("state", int'(state), es);
        cmp("ready", int'(ready), (es == 3) ? 1 : 0);
        cmp("rst_out", int'(rst_out), (es == 3) ? 0 : 1);
        cmp("lock_lost", int'(lock_lost), int'(m_lost));
        cmp("loss_count", int'(loss_count), LOSS_EN ? m_loss : 0);
        if (lock_lost) pulse_cnt++;
    endtask

    task automatic applyStimulus(input logic v, input int n);
        locked = v;
        repeat (n) @(negedge clock_in);
    endtask

    task automatic runCycles(input logic v, input int n);
        locked = v;
        repeat (n) begin
            @(negedge clock_in);
            checkOutput();
        end
    endtask

    typedef struct {
        logic lk;
        int   n;
        int   st;
        logic rdy;
        logic ro;
        logic ll;
        int   loss;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b0, 3,  0, 1'b0, 1'b1, 1'b0, 0};
        vecs[1]  = '{1'b1, 2,  0, 1'b0, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b1, 1,  1, 1'b0, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b1, 8,  2, 1'b0, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b1, 3,  2, 1'b0, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b1, 1,  3, 1'b1, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 2,  3, 1'b1, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 1,  0, 1'b0, 1'b1, 1'b1, 1};
        vecs[8]  = '{1'b0, 1,  0, 1'b0, 1'b1, 1'b0, 1};
        vecs[9]  = '{1'b1, 5,  1, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 3,  0, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b1, 14, 2, 1'b0, 1'b1, 1'b0, 1};
        vecs[12] = '{1'b1, 1,  3, 1'b1, 1'b0, 1'b0, 1};

        repeat (3) @(negedge clock_in);
        cmp("reset_state", int'(state), 0);
        cmp("reset_rst_out", int'(rst_out), 1);
        cmp("reset_ready", int'(ready), 0);
        cmp("reset_lock_lost", int'(lock_lost), 0);
        cmp("reset_loss_count", int'(loss_count), 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].lk, vecs[i].n);
            cmp($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            cmp($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].rdy));
            cmp($sformatf("vec%0d_rst_out", i), int'(rst_out), int'(vecs[i].ro));
            cmp($sformatf("vec%0d_lock_lost", i), int'(lock_lost), int'(vecs[i].ll));
            cmp($sformatf("vec%0d_loss", i), int'(loss_count), LOSS_EN ? vecs[i].loss : 0);
        end

        // Many lock losses from RUN: every one pulses, the counter saturates.
        pulse_cnt = 0;
        for (int e = 0; e < 260; e++) begin
            runCycles(1'b0, 3);
            runCycles(1'b1, 15);
        end
        cmp("loss_pulses", pulse_cnt, 260);
        cmp("loss_saturated", int'(loss_count), LOSS_EN ? 255 : 0);

        // Reset asserted while holding the downstream reset takes effect without a clock edge.
        runCycles(1'b0, 3);
        runCycles(1'b1, 12);
        cmp("hold_state", int'(state), 2);
        #2 reset = 1'b1;
        #1;
        cmp("async_state", int'(state), 0);
        cmp("async_rst_out", int'(rst_out), 1);
        cmp("async_ready", int'(ready), 0);
        cmp("async_lock_lost", int'(lock_lost), 0);
        cmp("async_loss", int'(loss_count), 0);
        @(negedge clock_in);
        reset = 1'b0;
        runCycles(1'b1, 14);
        cmp("restart_not_ready", int'(ready), 0);
        runCycles(1'b1, 1);
        cmp("restart_ready", int'(ready), 1);

        // Randomized lock behaviour with occasional asynchronous resets.
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                #2 reset = 1'b1;
                @(negedge clock_in);
                checkOutput();
                reset = 1'b0;
            end
            if ($urandom_range(0, 2) != 0)
                runCycles(1'b1, $urandom_range(1, 25));
            else
                runCycles(1'b0, $urandom_range(1, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
